// File: rtl/jtpang_objdma_pkg.sv
// jtpang_objdma_pkg
// Shared definitions for the Pang object-table DMA controller:
//   - OBJ_AW : default byte-address width of the object table (512 bytes)
//   - state_t: 2-bit controller state encoding IDLE/REQ/COPY/DONE
package jtpang_objdma_pkg;

  localparam int OBJ_AW = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COPY = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// jtframe_dual_ram
// Simple dual-port RAM: one synchronous write port, one registered read port,
// both on the same clock. Contents are not initialised.
// Ports:
//   clk     in   clock
//   i_we    in   write enable
//   i_waddr in   AW  write address
//   i_data  in   DW  write data
//   i_raddr in   AW  read address
//   o_q     out  DW  read data, one clk after i_raddr
module jtframe_dual_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_data,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_data;
    o_q <= r_mem[i_raddr];
  end

endmodule

// File: rtl/jtpang_objdma.sv
// jtpang_objdma
// Object-table DMA controller for the Pang video path. On a CPU request it
// takes the CPU bus, copies the object attribute RAM into the inactive half
// of a double-buffered shadow table, and flips the active half at the next
// vertical blank so the object engine always reads a whole frame's table.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   cen       in   pixel clock enable; all state advances only when high
//   LVBL      in   vertical blank, active low
//   dma_go    in   one-cen copy request strobe from the CPU decoder
//   busak_n   in   CPU bus acknowledge, active low
//   busrq     out  CPU bus request
//   src_addr  out  AW  attribute RAM read address
//   src_data  in   8   attribute RAM data, one cen step after src_addr
//   buf_addr  in   AW  object engine read address into the active bank
//   buf_dout  out  8   active-bank data, one clk after buf_addr
//   busy      out  high from request acceptance until copy completion
//   bank      out  bank currently read by the object engine
module jtpang_objdma
  import jtpang_objdma_pkg::*;
#(
  parameter int AW = OBJ_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq,
  output logic [AW-1:0] src_addr,
  input  logic [7:0]    src_data,
  input  logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_dout,
  output logic          busy,
  output logic          bank
);

  // The counter is one bit wider than the table so completion is a distinct
  // value (2^AW) rather than a wrap back to address 0.
  localparam logic [AW:0]   CNT_END = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        r_state, w_state_nx;
  logic [AW:0]   r_cnt, w_cnt_nx;
  logic [AW-1:0] r_src_addr, w_src_nx;
  logic          r_busrq, w_busrq_nx;
  logic          r_busy, w_busy_nx;
  logic          r_bank, w_bank_nx;
  logic          r_pending, w_pending_nx;
  logic          r_swap, w_swap_nx;
  logic          r_lvbl_last;
  logic          w_lvbl_fall;
  logic          w_swap_ready;
  logic          w_we;
  logic          w_ram_we;
  logic [AW-1:0] w_waddr;

  // The byte on src_data belongs to the address issued one step earlier,
  // which is always counter-1. At completion the counter is 2^AW and the low
  // bits wrap to 2^AW-1, the last table entry.
  assign w_waddr  = r_cnt[AW-1:0] - ADR_ONE;
  assign w_ram_we = w_we & ~rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state and control
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_src_nx     = r_src_addr;
    w_busrq_nx   = r_busrq;
    w_busy_nx    = r_busy;
    w_bank_nx    = r_bank;
    w_pending_nx = r_pending;
    w_swap_nx    = r_swap;
    w_we         = 1'b0;
    w_lvbl_fall  = r_lvbl_last & ~LVBL;
    // A finishing copy counts as ready to show: all of its writes are done.
    w_swap_ready = r_swap | (r_state == DONE);

    if (cen) begin
      // Requests during a copy collapse into a single pending flag.
      if (dma_go && r_busy) w_pending_nx = 1'b1;

      case (r_state)
        IDLE: begin
          if (dma_go || r_pending) begin
            w_state_nx   = REQ;
            w_busy_nx    = 1'b1;
            w_busrq_nx   = 1'b1;
            w_pending_nx = 1'b0;
          end
        end
        REQ: begin
          if (!busak_n) begin
            w_state_nx = COPY;
            w_cnt_nx   = '0;
          end
        end
        COPY: begin
          // Losing the bus simply stalls here: counter, address and the
          // byte awaiting its write all hold until the grant returns.
          if (!busak_n) begin
            w_we = (r_cnt != '0);
            if (r_cnt == CNT_END) begin
              w_state_nx = DONE;
            end else begin
              w_src_nx = r_cnt[AW-1:0];
              w_cnt_nx = r_cnt + CNT_ONE;
            end
          end
        end
        DONE: begin
          w_busrq_nx = 1'b0;
          w_swap_nx  = 1'b1;
          // With another request queued, busy bridges straight into it.
          w_busy_nx  = r_pending | dma_go;
          w_state_nx = IDLE;
        end
        default: w_state_nx = IDLE;
      endcase

      // Flip banks on vblank only when no copy is writing, so the engine
      // never switches onto a half-written bank.
      if (w_lvbl_fall && w_swap_ready && (r_state != COPY)) begin
        w_bank_nx = ~r_bank;
        w_swap_nx = 1'b0;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_src_addr  <= '0;
      r_busrq     <= 1'b0;
      r_busy      <= 1'b0;
      r_bank      <= 1'b0;
      r_pending   <= 1'b0;
      r_swap      <= 1'b0;
      r_lvbl_last <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nx;
      r_src_addr <= w_src_nx;
      r_busrq    <= w_busrq_nx;
      r_busy     <= w_busy_nx;
      r_bank     <= w_bank_nx;
      r_pending  <= w_pending_nx;
      r_swap     <= w_swap_nx;
      if (cen) r_lvbl_last <= LVBL;
    end
  end

  // Shadow table: DMA writes the hidden half, the engine reads the shown half.
  jtframe_dual_ram #(
    .DW (8),
    .AW (AW+1)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr ({~r_bank, w_waddr}),
    .i_data  (src_data),
    .i_raddr ({r_bank, buf_addr}),
    .o_q     (buf_dout)
  );

  assign busrq    = r_busrq;
  assign busy     = r_busy;
  assign bank     = r_bank;
  assign src_addr = r_src_addr;

endmodule

// File: tb/tb_jtpang_objdma.sv
`timescale 1ns/1ps
module tb_jtpang_objdma;

  localparam int AW = 9;
  localparam int N  = 1 << AW;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          cen      = 1'b0;
  logic          LVBL     = 1'b1;
  logic          dma_go   = 1'b0;
  logic          busak_n  = 1'b1;
  logic          busrq;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_data = 8'd0;
  logic [AW-1:0] buf_addr = '0;
  logic [7:0]    buf_dout;
  logic          busy;
  logic          bank;

  int errors = 0;
  int checks = 0;

  // Reference: source memory, both shadow halves, shown bank, swap owed.
  logic [7:0] src_mem [N];
  logic [7:0] shadow  [2][N];
  bit         model_valid [2];
  bit         model_bank = 1'b0;
  bit         model_swap = 1'b0;

  bit            addr_hold = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic [7:0]    exp_q;
  bit            exp_v = 1'b0;

  jtpang_objdma #(.AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .LVBL     (LVBL),
    .dma_go   (dma_go),
    .busak_n  (busak_n),
    .busrq    (busrq),
    .src_addr (src_addr),
    .src_data (src_data),
    .buf_addr (buf_addr),
    .buf_dout (buf_dout),
    .busy     (busy),
    .bank     (bank)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(negedge clk); cen = ~cen; end

  // Attribute RAM: registered read of src_addr.
  always @(posedge clk) src_data <= src_mem[src_addr];

  // Object engine address: random unless a test pins it.
  initial forever begin
    @(negedge clk);
    buf_addr = addr_hold ? hold_addr : AW'($urandom_range(0, N-1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare: shown bank and its read data against the model.
  always @(posedge clk) begin
    exp_v <= model_valid[model_bank];
    exp_q <= shadow[model_bank][buf_addr];
  end
  always @(negedge clk) begin
    if (exp_v) chk("buf_dout", {24'd0, buf_dout}, {24'd0, exp_q});
    chk("bank", {31'd0, bank}, {31'd0, model_bank});
  end

  task automatic cstep();
    @(posedge clk);
    while (!cen) @(posedge clk);
    #1;
  endtask

  task automatic go();
    dma_go = 1'b1;
    cstep();
    dma_go = 1'b0;
  endtask

  task automatic rand_src();
    for (int i = 0; i < N; i++) src_mem[i] = 8'($urandom);
  endtask

  // A finished copy lands in the hidden half and is owed a swap.
  task automatic complete();
    bit nb;
    nb = !model_bank;
    for (int i = 0; i < N; i++) shadow[nb][i] = src_mem[i];
    model_valid[nb] = 1'b1;
    model_swap = 1'b1;
  endtask

  task automatic vblank();
    LVBL = 1'b0;
    cstep();
    if (model_swap) begin
      model_bank = !model_bank;
      model_swap = 1'b0;
    end
    repeat (4) cstep();
    LVBL = 1'b1;
    repeat (2) cstep();
  endtask

  task automatic sweep();
    addr_hold = 1'b1;
    for (int a = 0; a < N; a++) begin
      hold_addr = AW'(a);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    addr_hold = 1'b0;
  endtask

  // Plays the CPU side of one copy: grants g steps after busrq rises,
  // optionally drops the grant, strobes dma_go, or resets mid-copy.
  // hi returns the number of steps busrq was seen high.
  task automatic serve(input int g, input int exp_wait, input int drop_at, input int drop_len,
                       input bit strobes, input int rst_at, output int hi);
    int w;
    hi = 0;
    w  = 0;
    while (busrq !== 1'b1 && w < 20) begin cstep(); w++; end
    chk("req_latency", w, exp_wait);
    if (busrq !== 1'b1) return;
    while (busrq === 1'b1 && hi < 3000) begin
      hi++;
      chk("busy_in_copy", {31'd0, busy}, 1);
      if (rst_at >= 0 && hi == g + 1 + rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_busrq", {31'd0, busrq}, 0);
        chk("rst_busy",  {31'd0, busy},  0);
        chk("rst_bank",  {31'd0, bank},  0);
        model_valid[!model_bank] = 1'b0;
        model_bank = 1'b0;
        model_swap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        dma_go = 1'b0;
        return;
      end
      busak_n = !(hi >= g && !(hi > g + drop_at && hi <= g + drop_at + drop_len));
      dma_go  = strobes && (hi == g + 50 || hi == g + 100 || hi == g + 150);
      cstep();
    end
    dma_go  = 1'b0;
    busak_n = 1'b1;
    chk("busrq_timeout", {31'd0, hi < 3000}, 1);
  endtask

  initial begin
    int hi, g, g2, da, dl, rises;
    model_valid[0] = 1'b0;
    model_valid[1] = 1'b0;

    // Reset values
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busrq0",   {31'd0, busrq}, 0);
    chk("rst_busy0",    {31'd0, busy},  0);
    chk("rst_bank0",    {31'd0, bank},  0);
    chk("rst_src_addr", {23'd0, src_addr}, 0);
    rst = 1'b0;
    repeat (3) cstep();

    // Single copy of n[7:0], grant 3 steps after busrq
    for (int i = 0; i < N; i++) src_mem[i] = 8'(i);
    go();
    serve(3, 0, 0, 0, 1'b0, -1, hi);
    chk("s1_busrq_len", hi, 517);
    chk("s1_busy_done", {31'd0, busy}, 0);
    complete();
    chk("s1_bank_before", {31'd0, bank}, 0);
    vblank();
    chk("s1_bank_after", {31'd0, bank}, 1);
    addr_hold = 1'b1;
    hold_addr = 9'h105;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("s1_rd_105", {24'd0, buf_dout}, 32'h05);
    addr_hold = 1'b0;
    sweep();

    // Bus lost for 10 steps at counter 200
    rand_src();
    g = $urandom_range(1, 6);
    go();
    serve(g, 0, 200, 10, 1'b0, -1, hi);
    chk("s2_busrq_len", hi, g + 514 + 10);
    chk("s2_busy_done", {31'd0, busy}, 0);
    complete();
    vblank();
    chk("s2_bank", {31'd0, bank}, 0);
    sweep();

    // Three strobes during a copy: exactly one more copy, busy bridged
    rand_src();
    g = $urandom_range(1, 6);
    go();
    serve(g, 0, 0, 0, 1'b1, -1, hi);
    chk("s3_len1", hi, g + 514);
    chk("s3_busy_bridge", {31'd0, busy}, 1);
    rand_src();
    g2 = $urandom_range(1, 6);
    serve(g2, 1, 0, 0, 1'b0, -1, hi);
    chk("s3_len2", hi, g2 + 514);
    chk("s3_busy_done", {31'd0, busy}, 0);
    complete();
    rises = 0;
    repeat (20) begin cstep(); if (busrq === 1'b1) rises++; end
    chk("s3_no_third", rises, 0);
    vblank();
    chk("s3_bank", {31'd0, bank}, 1);
    sweep();
    vblank();
    chk("s3_no_retoggle", {31'd0, bank}, 1);

    // Two separate copies in one frame, second requested while swap owed
    rand_src();
    g = $urandom_range(1, 6);
    go();
    serve(g, 0, 0, 0, 1'b0, -1, hi);
    chk("s4_lenA", hi, g + 514);
    complete();
    repeat (5) cstep();
    rand_src();
    g = $urandom_range(1, 6);
    go();
    serve(g, 0, 0, 0, 1'b0, -1, hi);
    chk("s4_lenB", hi, g + 514);
    complete();
    chk("s4_bank_before", {31'd0, bank}, 1);
    vblank();
    chk("s4_bank", {31'd0, bank}, 0);
    sweep();
    vblank();
    chk("s4_no_retoggle", {31'd0, bank}, 0);

    // Reset at counter 300, grant left asserted afterwards
    rand_src();
    g = $urandom_range(1, 6);
    go();
    serve(g, 0, 0, 0, 1'b0, 300, hi);
    repeat (20) cstep();
    chk("s5_busrq_idle", {31'd0, busrq}, 0);
    chk("s5_busy_idle",  {31'd0, busy},  0);
    chk("s5_src_addr",   {23'd0, src_addr}, 0);
    busak_n = 1'b1;
    vblank();
    chk("s5_bank", {31'd0, bank}, 0);
    sweep();

    // Recovery copy with a random bus drop
    rand_src();
    g  = $urandom_range(1, 6);
    da = $urandom_range(20, 480);
    dl = $urandom_range(1, 15);
    go();
    serve(g, 0, da, dl, 1'b0, -1, hi);
    chk("s6_busrq_len", hi, g + 514 + dl);
    complete();
    vblank();
    chk("s6_bank", {31'd0, bank}, 1);
    sweep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
